// File: rtl/dcache_meta_arbiter.sv
// Metadata array arbiter for the L1 D-cache: fixed priority with aging override,
// single-cycle read-after-write blocking and a one-cycle response tag pipeline.
module dcache_meta_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned IDX_BITS     = 6,
    parameter int unsigned TAG_BITS     = 20,
    parameter int unsigned COH_BITS     = 2,
    parameter int unsigned N_WAYS       = 4,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned ID_BITS      = $clog2(N_REQ)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0]             req_write,
    input  logic [N_REQ*IDX_BITS-1:0]    req_idx,
    input  logic [N_REQ*TAG_BITS-1:0]    req_tag,
    input  logic [N_REQ*N_WAYS-1:0]      req_way_en,
    input  logic [N_REQ*COH_BITS-1:0]    req_coh,
    input  logic                         arr_ready,
    output logic                         arr_en,
    output logic                         arr_write,
    output logic [IDX_BITS-1:0]          arr_idx,
    output logic [TAG_BITS-1:0]          arr_tag,
    output logic [N_WAYS-1:0]            arr_way_en,
    output logic [COH_BITS-1:0]          arr_coh,
    output logic                         resp_valid,
    output logic                         resp_write,
    output logic [ID_BITS-1:0]           resp_id,
    output logic [N_REQ-1:0]             starved
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]    age [N_REQ];
    logic                wr_pend_valid;
    logic [IDX_BITS-1:0] wr_pend_idx;
    logic                resp_valid_q;
    logic                resp_write_q;
    logic [ID_BITS-1:0]  resp_id_q;

    logic [N_REQ-1:0]    eligible;
    logic [N_REQ-1:0]    starved_vec;
    logic [N_REQ-1:0]    grant;
    logic [ID_BITS-1:0]  win;
    logic                found;

    always_comb begin
        eligible    = req_valid;
        starved_vec = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            starved_vec[i] = (age[i] == LIMIT);
            if (wr_pend_valid && !req_write[i] &&
                req_idx[i*IDX_BITS +: IDX_BITS] == wr_pend_idx)
                eligible[i] = 1'b0;
        end
    end

    // Starved requesters are searched first; plain priority only if none are eligible.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && eligible[i] && starved_vec[i]) begin
                found = 1'b1;
                win   = ID_BITS'(i);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && eligible[i]) begin
                found = 1'b1;
                win   = ID_BITS'(i);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found && arr_ready && !reset)
            grant[win] = 1'b1;
    end

    assign req_ready  = grant;
    assign arr_en     = |grant;
    assign arr_write  = req_write[win];
    assign arr_idx    = req_idx[win*IDX_BITS +: IDX_BITS];
    assign arr_tag    = req_tag[win*TAG_BITS +: TAG_BITS];
    assign arr_way_en = req_way_en[win*N_WAYS +: N_WAYS];
    assign arr_coh    = req_coh[win*COH_BITS +: COH_BITS];

    // Gating with reset makes the reset values visible while reset is held,
    // so a response registered just before reset is never presented.
    assign resp_valid = resp_valid_q & ~reset;
    assign resp_write = resp_write_q & ~reset;
    assign resp_id    = reset ? '0 : resp_id_q;
    assign starved    = reset ? '0 : starved_vec;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_pend_valid <= 1'b0;
            wr_pend_idx   <= '0;
            resp_valid_q  <= 1'b0;
            resp_write_q  <= 1'b0;
            resp_id_q     <= '0;
            for (int unsigned i = 0; i < N_REQ; i++)
                age[i] <= '0;
        end else begin
            wr_pend_valid <= arr_en & arr_write;
            if (arr_en && arr_write)
                wr_pend_idx <= arr_idx;
            resp_valid_q <= arr_en;
            if (arr_en) begin
                resp_write_q <= arr_write;
                resp_id_q    <= win;
            end
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (grant[i] || !req_valid[i])
                    age[i] <= '0;
                else if (age[i] != LIMIT)
                    age[i] <= age[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_meta_arbiter.sv
// Directed bench for dcache_meta_arbiter: reset, single read, aging, RAW hazard,
// backpressure and reset while a response is pending.
module tb_dcache_meta_arbiter;

    localparam int N_REQ    = 4;
    localparam int IDX_BITS = 6;
    localparam int TAG_BITS = 20;
    localparam int COH_BITS = 2;
    localparam int N_WAYS   = 4;
    localparam int ID_BITS  = 2;

    logic                      clock;
    logic                      reset;
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ-1:0]          req_write;
    logic [N_REQ*IDX_BITS-1:0] req_idx;
    logic [N_REQ*TAG_BITS-1:0] req_tag;
    logic [N_REQ*N_WAYS-1:0]   req_way_en;
    logic [N_REQ*COH_BITS-1:0] req_coh;
    logic                      arr_ready;
    logic                      arr_en;
    logic                      arr_write;
    logic [IDX_BITS-1:0]       arr_idx;
    logic [TAG_BITS-1:0]       arr_tag;
    logic [N_WAYS-1:0]         arr_way_en;
    logic [COH_BITS-1:0]       arr_coh;
    logic                      resp_valid;
    logic                      resp_write;
    logic [ID_BITS-1:0]        resp_id;
    logic [N_REQ-1:0]          starved;

    int checks = 0;
    int errors = 0;

    dcache_meta_arbiter #(
        .N_REQ(N_REQ), .IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS),
        .COH_BITS(COH_BITS), .N_WAYS(N_WAYS), .STARVE_LIMIT(8), .ID_BITS(ID_BITS)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_idx(req_idx), .req_tag(req_tag), .req_way_en(req_way_en), .req_coh(req_coh),
        .arr_ready(arr_ready), .arr_en(arr_en), .arr_write(arr_write), .arr_idx(arr_idx),
        .arr_tag(arr_tag), .arr_way_en(arr_way_en), .arr_coh(arr_coh),
        .resp_valid(resp_valid), .resp_write(resp_write), .resp_id(resp_id),
        .starved(starved)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_all();
        req_valid  = '0;
        req_write  = '0;
        req_idx    = '0;
        req_tag    = '0;
        req_way_en = '0;
        req_coh    = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input int idx,
                           input int tag, input int way, input int coh);
        req_valid[i] = v;
        req_write[i] = w;
        req_idx[i*IDX_BITS +: IDX_BITS]   = IDX_BITS'(idx);
        req_tag[i*TAG_BITS +: TAG_BITS]   = TAG_BITS'(tag);
        req_way_en[i*N_WAYS +: N_WAYS]    = N_WAYS'(way);
        req_coh[i*COH_BITS +: COH_BITS]   = COH_BITS'(coh);
    endtask

    task automatic idle(input int n);
        clear_all();
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        arr_ready = 1'b1;
        clear_all();
        cyc(); cyc();
        settle();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (arr_en !== 1'b0) begin errors++; $display("FAIL reset_arr_en: got %b expected 0", arr_en); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_resp_id: got %0d expected 0", resp_id); end
        checks++; if (starved !== 4'b0000) begin errors++; $display("FAIL reset_starved: got %b expected 0000", starved); end
        cyc();
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_single_read();
        set_req(2, 1'b1, 1'b0, 5, 0, 0, 0);
        settle();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_req_ready: got %b expected 0100", req_ready); end
        checks++; if (arr_en !== 1'b1) begin errors++; $display("FAIL single_arr_en: got %b expected 1", arr_en); end
        checks++; if (arr_idx !== 6'd5) begin errors++; $display("FAIL single_arr_idx: got %0d expected 5", arr_idx); end
        checks++; if (arr_write !== 1'b0) begin errors++; $display("FAIL single_arr_write: got %b expected 0", arr_write); end
        cyc();
        clear_all();
        settle();
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid: got %b expected 1", resp_valid); end
        checks++; if (resp_id !== 2'd2) begin errors++; $display("FAIL single_resp_id: got %0d expected 2", resp_id); end
        checks++; if (resp_write !== 1'b0) begin errors++; $display("FAIL single_resp_write: got %b expected 0", resp_write); end
        checks++; if (arr_en !== 1'b0) begin errors++; $display("FAIL single_idle_arr_en: got %b expected 0", arr_en); end
        cyc();
        settle();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_resp_gone: got %b expected 0", resp_valid); end
        idle(1);
    endtask

    // Req 1 joins one cycle late so req 3 reaches the limit alone at cycle 8.
    task automatic test_contention();
        logic [3:0] exp_rdy;
        logic [3:0] exp_stv;
        clear_all();
        for (int c = 0; c <= 10; c++) begin
            set_req(0, 1'b1, 1'b0, 10, 0, 0, 0);
            set_req(3, 1'b1, 1'b0, 13, 0, 0, 0);
            if (c >= 1) set_req(1, 1'b1, 1'b0, 11, 0, 0, 0);
            settle();
            exp_rdy = (c == 8) ? 4'b1000 : (c == 9) ? 4'b0010 : 4'b0001;
            exp_stv = (c == 8) ? 4'b1000 : (c == 9) ? 4'b0010 : 4'b0000;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL contention_ready c=%0d: got %b expected %b", c, req_ready, exp_rdy); end
            checks++; if (starved !== exp_stv) begin errors++; $display("FAIL contention_starved c=%0d: got %b expected %b", c, starved, exp_stv); end
            if (c == 8) begin
                checks++; if (arr_idx !== 6'd13) begin errors++; $display("FAIL contention_idx: got %0d expected 13", arr_idx); end
            end
            if (c == 9) begin
                checks++; if (resp_id !== 2'd3) begin errors++; $display("FAIL contention_resp_id: got %0d expected 3", resp_id); end
            end
            cyc();
        end
        idle(2);
    endtask

    task automatic test_raw_hazard();
        clear_all();
        set_req(1, 1'b1, 1'b1, 9, 'hABCDE, 4'b0010, 2);
        settle();
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL raw_wr_ready: got %b expected 0010", req_ready); end
        checks++; if (arr_write !== 1'b1) begin errors++; $display("FAIL raw_arr_write: got %b expected 1", arr_write); end
        checks++; if (arr_tag !== 20'hABCDE) begin errors++; $display("FAIL raw_arr_tag: got %h expected abcde", arr_tag); end
        checks++; if (arr_coh !== 2'd2) begin errors++; $display("FAIL raw_arr_coh: got %0d expected 2", arr_coh); end
        checks++; if (arr_way_en !== 4'b0010) begin errors++; $display("FAIL raw_arr_way: got %b expected 0010", arr_way_en); end
        cyc();
        clear_all();
        set_req(0, 1'b1, 1'b0, 9, 0, 0, 0);
        set_req(2, 1'b1, 1'b0, 3, 0, 0, 0);
        settle();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL raw_block_ready: got %b expected 0100", req_ready); end
        checks++; if (arr_idx !== 6'd3) begin errors++; $display("FAIL raw_block_idx: got %0d expected 3", arr_idx); end
        checks++; if (resp_valid !== 1'b1 || resp_write !== 1'b1 || resp_id !== 2'd1) begin
            errors++; $display("FAIL raw_wr_resp: got v=%b w=%b id=%0d expected v=1 w=1 id=1", resp_valid, resp_write, resp_id); end
        cyc();
        set_req(2, 1'b0, 1'b0, 0, 0, 0, 0);
        settle();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL raw_after_ready: got %b expected 0001", req_ready); end
        checks++; if (arr_idx !== 6'd9) begin errors++; $display("FAIL raw_after_idx: got %0d expected 9", arr_idx); end
        cyc();
        idle(2);
    endtask

    task automatic test_backpressure();
        clear_all();
        arr_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 1'b0, 20 + i, 0, 0, 0);
            settle();
            checks++; if (req_ready !== 4'b0000 || arr_en !== 1'b0) begin
                errors++; $display("FAIL bp_no_grant k=%0d: got ready=%b en=%b expected 0000/0", k, req_ready, arr_en); end
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_resp k=%0d: got %b expected 0", k, resp_valid); end
            if (k >= 8) begin
                checks++; if (starved !== 4'b1111) begin errors++; $display("FAIL bp_starved k=%0d: got %b expected 1111", k, starved); end
            end
            cyc();
        end
        arr_ready = 1'b1;
        settle();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready: got %b expected 0001", req_ready); end
        checks++; if (arr_idx !== 6'd20) begin errors++; $display("FAIL bp_release_idx: got %0d expected 20", arr_idx); end
        cyc();
        settle();
        checks++; if (starved !== 4'b1110) begin errors++; $display("FAIL bp_multi_starved: got %b expected 1110", starved); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_multi_ready: got %b expected 0010", req_ready); end
        cyc();
        idle(2);
    endtask

    task automatic test_reset_midflight();
        clear_all();
        set_req(2, 1'b1, 1'b0, 7, 0, 0, 0);
        settle();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_grant: got %b expected 0100", req_ready); end
        cyc();
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 1'b0, 30 + i, 0, 0, 0);
        reset = 1'b1;
        settle();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_resp_in_reset: got %b expected 0", resp_valid); end
        checks++; if (req_ready !== 4'b0000 || arr_en !== 1'b0) begin
            errors++; $display("FAIL mid_grant_in_reset: got ready=%b en=%b expected 0000/0", req_ready, arr_en); end
        cyc();
        reset = 1'b0;
        settle();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_resp_after: got %b expected 0", resp_valid); end
        checks++; if (starved !== 4'b0000) begin errors++; $display("FAIL mid_starved_after: got %b expected 0000", starved); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ready_after: got %b expected 0001", req_ready); end
        cyc();
        idle(1);
    endtask

    initial begin
        reset = 1'b1;
        arr_ready = 1'b1;
        clear_all();
        test_reset();
        test_single_read();
        test_contention();
        test_raw_hazard();
        test_backpressure();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
